// File: rtl/cache_lookup_initiator.sv
// cache_lookup_initiator
// Requester-side master for the cache tag/LRU lookup controller. A client byte
// address is split into tag and index, a single lookup is issued over the
// it_valid/it_ready channel, and the hit/miss result is collected over the
// hm_valid/hm_ready channel. Exactly one response per accepted request is
// returned to the client. A watchdog aborts lookups whose result never shows up.
//
// Optional build macro: CACHE_LOOKUP_STATS_EN adds saturating hit/miss/timeout
// counters (hit_cnt_o, miss_cnt_o, timeout_cnt_o), updated at the response
// handshake.

module cache_lookup_initiator #(
  parameter int index_width    = 10,
  parameter int tag_width      = 16,
  parameter int offset_width   = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        req_valid_i,
  input  logic [tag_width+index_width+offset_width-1:0] req_addr_i,
  output logic                                        req_ready_o,
  output logic [index_width-1:0]                      index_o,
  output logic [tag_width-1:0]                        tag_o,
  output logic                                        it_valid_o,
  input  logic                                        it_ready_i,
  input  logic                                        hm_valid_i,
  input  logic                                        hit_miss_i,
  input  logic [1:0]                                  col_i,
  output logic                                        hm_ready_o,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic                                        rsp_hit_o,
  output logic [1:0]                                  rsp_col_o,
  output logic                                        rsp_err_o
`ifdef CACHE_LOOKUP_STATS_EN
  ,
  output logic [31:0]                                 hit_cnt_o,
  output logic [31:0]                                 miss_cnt_o,
  output logic [15:0]                                 timeout_cnt_o
`endif
);

  localparam int ADDR_W = tag_width + index_width + offset_width;

  // The watchdog only has to count up to timeout_cycles-1.
  localparam int WD_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam bit WD_EN = (timeout_cycles != 0);
  localparam logic [WD_W-1:0] WD_LAST = (timeout_cycles > 0) ? WD_W'(timeout_cycles - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [tag_width-1:0]   tag_q;
  logic [index_width-1:0] index_q;
  logic [WD_W-1:0]        watchdog;
  logic                   res_hit;
  logic [1:0]             res_col;
  logic                   res_err;

  logic                   load_req;
  logic                   it_fire;
  logic                   hm_take;
  logic                   wd_expire;
  logic                   rsp_fire;

  // Offset bits select a byte within a line and play no part in the lookup.
  logic                   unused_offset;
  assign unused_offset = ^req_addr_i[offset_width-1:0];

  // A timeout fires on the last permitted WAIT_HM cycle when no result came in.
  logic                   wd_at_last;
  assign wd_at_last = WD_EN && (watchdog == WD_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs, all derived from the current state.
  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    it_valid_o  = 1'b0;
    hm_ready_o  = 1'b0;
    rsp_valid_o = 1'b0;
    load_req    = 1'b0;
    it_fire     = 1'b0;
    hm_take     = 1'b0;
    wd_expire   = 1'b0;
    rsp_fire    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          load_req  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        it_valid_o = 1'b1;
        if (it_ready_i) begin
          it_fire   = 1'b1;
          state_nxt = WAIT_HM;
        end
      end
      WAIT_HM: begin
        hm_ready_o = 1'b1;
        // A result arriving on the expiry cycle still counts as a real result.
        if (hm_valid_i) begin
          hm_take   = 1'b1;
          state_nxt = RESP;
        end else if (wd_at_last) begin
          wd_expire = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Tag/index capture; held until the next accepted request so the controller
  // sees stable values for the whole ISSUE phase.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_q   <= '0;
      index_q <= '0;
    end else if (load_req) begin
      tag_q   <= req_addr_i[ADDR_W-1 -: tag_width];
      index_q <= req_addr_i[offset_width+index_width-1 : offset_width];
    end
  end

  // Watchdog: cleared when the lookup is handed off, counts every WAIT_HM cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      watchdog <= '0;
    end else if (it_fire) begin
      watchdog <= '0;
    end else if (state == WAIT_HM) begin
      watchdog <= watchdog + 1'b1;
    end
  end

  // Result capture: way is forced to zero on a miss or a timeout.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      res_hit <= 1'b0;
      res_col <= 2'd0;
      res_err <= 1'b0;
    end else if (hm_take) begin
      res_hit <= hit_miss_i;
      res_col <= hit_miss_i ? col_i : 2'd0;
      res_err <= 1'b0;
    end else if (wd_expire) begin
      res_hit <= 1'b0;
      res_col <= 2'd0;
      res_err <= 1'b1;
    end
  end

  assign tag_o     = tag_q;
  assign index_o   = index_q;
  assign rsp_hit_o = res_hit;
  assign rsp_col_o = res_col;
  assign rsp_err_o = res_err;

`ifdef CACHE_LOOKUP_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [15:0] timeout_cnt;

  // Response statistics; a timed-out lookup is counted only as a timeout.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      timeout_cnt <= '0;
    end else if (rsp_fire) begin
      if (res_err) begin
        timeout_cnt <= sat_inc16(timeout_cnt);
      end else if (res_hit) begin
        hit_cnt <= sat_inc32(hit_cnt);
      end else begin
        miss_cnt <= sat_inc32(miss_cnt);
      end
    end
  end

  assign hit_cnt_o     = hit_cnt;
  assign miss_cnt_o    = miss_cnt;
  assign timeout_cnt_o = timeout_cnt;
`endif

endmodule

// File: tb/tb_cache_lookup_initiator.sv
// Testbench for cache_lookup_initiator: directed lookups against a bench-side
// controller/client, a queue-based response model checked every cycle, and
// literal expectations on the first few transactions.

module tb_cache_lookup_initiator;

  localparam int IW = 10;
  localparam int TW = 16;
  localparam int OW = 4;
  localparam int TO = 8;
  localparam int AW = TW + IW + OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          it_valid;
  logic          it_ready = 1'b0;
  logic          hm_valid = 1'b0;
  logic          hit_miss = 1'b0;
  logic [1:0]    col_in = 2'd0;
  logic          hm_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [1:0]    rsp_col;
  logic          rsp_err;
`ifdef CACHE_LOOKUP_STATS_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
  logic [15:0]   timeout_cnt;
`endif

  cache_lookup_initiator #(
    .index_width(IW), .tag_width(TW), .offset_width(OW), .timeout_cycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .index_o(idx), .tag_o(tag), .it_valid_o(it_valid), .it_ready_i(it_ready),
    .hm_valid_i(hm_valid), .hit_miss_i(hit_miss), .col_i(col_in), .hm_ready_o(hm_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hit_o(rsp_hit), .rsp_col_o(rsp_col), .rsp_err_o(rsp_err)
`ifdef CACHE_LOOKUP_STATS_EN
    ,
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .timeout_cnt_o(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic [1:0] col;
    logic       err;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [TW-1:0] exp_tag = '0;
  logic [IW-1:0] exp_idx = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int it_fires = 0;
  int rsp_fires = 0;
  int n_issued = 0;
  int n_answered = 0;
  int it_cyc = 0;
  int hm_cyc = 0;
  int m_hits = 0;
  int m_miss = 0;
  int m_to = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every cycle: exactly one phase active, ISSUE carries the model's tag/index,
  // RESP carries the model's oldest pending response.
  always @(negedge clk) begin
    if (rst_n) begin
      check("one_phase", $countones({req_ready, it_valid, hm_ready, rsp_valid}), 1);
      if (it_valid) begin
        it_cyc++;
        check("tag_o", tag, exp_tag);
        check("index_o", idx, exp_idx);
      end
      if (hm_ready) hm_cyc++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", 1, 0);
        end else begin
          check("rsp_hit", rsp_hit, exp_q[0].hit);
          check("rsp_col", rsp_col, exp_q[0].col);
          check("rsp_err", rsp_err, exp_q[0].err);
        end
      end
    end
  end

  // Handshake bookkeeping at the active edge (inputs are stable there).
  always @(posedge clk) begin
    rsp_t r;
    cyc++;
    if (rst_n && it_valid && it_ready) it_fires++;
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_fires++;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.err) m_to++;
        else if (r.hit) m_hits++;
        else m_miss++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // Present a request and wait (bounded) until the block takes it; starts and
  // ends on a falling edge.
  task automatic present(input logic [AW-1:0] addr, output bit ok);
    int g;
    exp_tag   = TW'(addr >> (IW + OW));
    exp_idx   = IW'(addr >> OW);
    req_addr  = addr;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    ok = req_ready;
    if (!ok) check("req_ready_wait", 0, 1);
  endtask

  // One complete lookup. hm_wait is the WAIT_HM cycle (0-based) on which the
  // result is presented; negative means never.
  task automatic run_lookup(input logic [AW-1:0] addr, input int it_stall, input int hm_wait,
                            input logic hit, input logic [1:0] col, input int rsp_stall,
                            input bit hold_valid, output int lat, output logic r_hit,
                            output logic [1:0] r_col, output logic r_err);
    rsp_t e;
    int   w;
    int   c0;
    bit   ok;
    e.err = (hm_wait < 0) || (hm_wait > TO - 1);
    e.hit = e.err ? 1'b0 : hit;
    e.col = (e.err || !hit) ? 2'd0 : col;
    w     = e.err ? TO - 1 : hm_wait;
    exp_q.push_back(e);
    present(addr, ok);
    c0 = cyc;
    it_cyc = 0;
    hm_cyc = 0;
    n_issued++;
    n_answered++;
    @(negedge clk);
    if (!hold_valid) req_valid = 1'b0;
    it_ready = 1'b0;
    repeat (it_stall) @(negedge clk);
    it_ready = 1'b1;
    @(negedge clk);
    it_ready = 1'b0;
    for (int n = 0; n <= w; n++) begin
      hm_valid = (n == hm_wait);
      hit_miss = (n == hm_wait) ? hit : 1'($urandom_range(0, 1));
      col_in   = (n == hm_wait) ? col : 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    hm_valid = 1'b0;
    lat   = cyc - c0;
    r_hit = rsp_hit;
    r_col = rsp_col;
    r_err = rsp_err;
    check("rsp_valid_present", rsp_valid, 1);
    rsp_ready = 1'b0;
    repeat (rsp_stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int         lat;
  logic       r_hit;
  logic [1:0] r_col;
  logic       r_err;
  int         it0;
  int         rsp0;
  bit         ok;

  initial begin
    // Reset state, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("rst_it_valid", it_valid, 0);
    check("rst_hm_ready", hm_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_tag", tag, 0);
    check("rst_index", idx, 0);
    check("rst_rsp_fields", {rsp_hit, rsp_col, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // Ideal hit: 30-bit address, so the tag is bits 29:14 and the index 13:4.
    run_lookup(30'h1234_5678, 0, 1, 1'b1, 2'd2, 0, 1'b0, lat, r_hit, r_col, r_err);
    check("hit_tag_literal", tag, 16'h48D1);
    check("hit_index_literal", idx, 10'h167);
    check("hit_latency", lat, 4);
    check("hit_rsp_literal", {r_hit, r_col, r_err}, 4'b1100);

    // Miss with issue and response backpressure.
    run_lookup(30'h0ABC_DEF0, 5, 1, 1'b0, 2'd3, 3, 1'b0, lat, r_hit, r_col, r_err);
    check("miss_it_valid_cycles", it_cyc, 6);
    check("miss_rsp_literal", {r_hit, r_col, r_err}, 4'b0000);
    check("miss_latency", lat, 9);

    // Result never arrives: watchdog abort.
    run_lookup(30'h3FFF_FFFF, 0, -1, 1'b1, 2'd1, 1, 1'b0, lat, r_hit, r_col, r_err);
    check("timeout_wait_cycles", hm_cyc, 8);
    check("timeout_rsp_literal", {r_hit, r_col, r_err}, 4'b0001);
    check("timeout_latency", lat, 10);

    // Result on the last permitted cycle beats the watchdog.
    run_lookup(30'h0000_0010, 0, 7, 1'b1, 2'd1, 0, 1'b0, lat, r_hit, r_col, r_err);
    check("late_hit_wait_cycles", hm_cyc, 8);
    check("late_hit_rsp_literal", {r_hit, r_col, r_err}, 4'b1010);

    // Asynchronous reset while waiting for a result: no response may follow.
    present(30'h2222_3330, ok);
    n_issued++;
    @(negedge clk);
    req_valid = 1'b0;
    it_ready  = 1'b1;
    @(negedge clk);
    it_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_hm_ready", hm_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hm_ready", hm_ready, 0);
    check("async_rst_tag", tag, 0);
    check("async_rst_index", idx, 0);
    check("async_rst_rsp", {rsp_valid, rsp_hit, rsp_col, rsp_err}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    hm_valid = 1'b1;
    hit_miss = 1'b1;
    col_in   = 2'd2;
    check("post_rst_req_ready", req_ready, 1);
    @(negedge clk);
    hm_valid = 1'b0;
    run_lookup(30'h1555_AAA0, 1, 0, 1'b1, 2'd3, 0, 1'b0, lat, r_hit, r_col, r_err);
    check("post_rst_rsp_literal", {r_hit, r_col, r_err}, 4'b1110);

    // Back-to-back with req_valid held high throughout.
    it0  = it_fires;
    rsp0 = rsp_fires;
    run_lookup(30'h0101_0100, 0, 1, 1'b1, 2'd0, 0, 1'b1, lat, r_hit, r_col, r_err);
    run_lookup(30'h0202_0200, 2, 0, 1'b0, 2'd1, 1, 1'b1, lat, r_hit, r_col, r_err);
    run_lookup(30'h0303_0300, 0, 3, 1'b1, 2'd3, 0, 1'b1, lat, r_hit, r_col, r_err);
    run_lookup(30'h0404_0400, 1, 2, 1'b0, 2'd2, 2, 1'b1, lat, r_hit, r_col, r_err);
    req_valid = 1'b0;
    check("b2b_issued", it_fires - it0, 4);
    check("b2b_responses", rsp_fires - rsp0, 4);
    repeat (3) @(negedge clk);

    check("all_issued", it_fires, n_issued);
    check("all_answered", rsp_fires, n_answered);
    check("model_drained", exp_q.size(), 0);
`ifdef CACHE_LOOKUP_STATS_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_miss);
    check("timeout_cnt", timeout_cnt, m_to);
    check("hit_cnt_literal", hit_cnt, 5);
    check("miss_cnt_literal", miss_cnt, 3);
    check("timeout_cnt_literal", timeout_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
